// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch master: FSM states, FIFO entry layout, fetch stride.
package instr_fetch_pkg;

  localparam int IF_ADDR_W    = 8;
  localparam int IF_DATA_W    = 32;
  localparam int FETCH_STRIDE = IF_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAITR = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] addr;
    logic [IF_DATA_W-1:0] rdata;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// req/gnt/rvalid instruction-memory bus; master = fetch unit, slave = memory.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  instr_req_o;
  logic [ADDR_WIDTH-1:0] instr_addr_o;
  logic                  instr_gnt_i;
  logic                  instr_rvalid_i;
  logic [DATA_WIDTH-1:0] instr_rdata_i;

  modport master (
    output instr_req_o, instr_addr_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries; flush wins over push/pop, head is read combinationally.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  entry_t                 wdata,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 rdata,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  entry_t        store [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_master.sv
// Sequential instruction prefetcher with branch redirect and one outstanding bus transaction.
// Optional FETCH_STATS_EN adds saturating request/wait/flush counters.
module instr_fetch_master
  import instr_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = IF_ADDR_W,
  parameter int                    DATA_WIDTH = IF_DATA_W,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_if.master         bus,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_pc_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]           stat_req_cnt_o,
  output logic [31:0]           stat_wait_cnt_o,
  output logic [31:0]           stat_flush_cnt_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]         FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rdata;
  } entry_t;

  fetch_state_e          state_q;
  logic                  req_q, discard_q;
  logic [ADDR_WIDTH-1:0] addr_q, tgt_q, tgt_aligned;
  logic                  rsp, push, pop, fifo_empty, slot_free;
  logic [CW-1:0]         fifo_count, count_nxt;
  entry_t                head, wentry;

  assign tgt_aligned = branch_addr_i & ~(STRIDE - ADDR_WIDTH'(1));
  assign rsp         = (state_q == WAITR) && bus.instr_rvalid_i;
  assign push        = rsp && !discard_q && !branch_i;
  assign pop         = !fifo_empty && instr_ready_i && !branch_i;
  assign wentry      = '{addr: addr_q, rdata: bus.instr_rdata_i};

  // Occupancy after this edge; in IDLE inflight is 0, and in WAITR the
  // completing response is already folded in via push, so this alone decides issue.
  always_comb begin
    count_nxt = fifo_count;
    if (branch_i) begin
      count_nxt = '0;
    end else begin
      if (push) count_nxt = count_nxt + CW'(1);
      if (pop)  count_nxt = count_nxt - CW'(1);
    end
  end
  assign slot_free = (count_nxt < FULL_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= BOOT_ADDR;
      tgt_q     <= BOOT_ADDR;
      discard_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (branch_i) addr_q <= tgt_aligned;
          if (slot_free) begin
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        REQ: begin
          // Address must stay put until rvalid, so the redirect target is parked.
          if (branch_i) begin
            discard_q <= 1'b1;
            tgt_q     <= tgt_aligned;
          end
          if (bus.instr_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= WAITR;
          end
        end
        WAITR: begin
          if (bus.instr_rvalid_i) begin
            discard_q <= 1'b0;
            if (branch_i)       addr_q <= tgt_aligned;
            else if (discard_q) addr_q <= tgt_q;
            else                addr_q <= addr_q + STRIDE;
            if (slot_free) begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end else if (branch_i) begin
            discard_q <= 1'b1;
            tgt_q     <= tgt_aligned;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .flush (branch_i),
    .rdata (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.instr_req_o  = req_q;
  assign bus.instr_addr_o = addr_q;
  assign instr_valid_o    = !fifo_empty;
  assign instr_rdata_o    = fifo_empty ? '0 : head.rdata;
  assign instr_pc_o       = fifo_empty ? '0 : head.addr;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_req_cnt_o   <= '0;
      stat_wait_cnt_o  <= '0;
      stat_flush_cnt_o <= '0;
    end else begin
      if (state_q == REQ && bus.instr_gnt_i && stat_req_cnt_o != '1)
        stat_req_cnt_o <= stat_req_cnt_o + 32'd1;
      if (state_q != IDLE && stat_wait_cnt_o != '1)
        stat_wait_cnt_o <= stat_wait_cnt_o + 32'd1;
      if (branch_i && stat_flush_cnt_o != '1)
        stat_flush_cnt_o <= stat_flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule
